// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: frame-level controller behind a UART byte receiver.
// Hunts for a two-byte header (HDR0, HDR1), collects an address and a data
// byte and issues one single-cycle register-write strobe per good frame.
// Inter-byte silence inside a frame longer than TIMEOUT_CLKS clocks aborts
// the frame with a frame_err pulse.
// Optional feature: define UART_FRAME_CHECKSUM_EN to append a checksum byte
// (addr + data, 8-bit wrap) to every frame; a bad checksum pulses frame_err.
//
// Handshake: rx_done is a one-cycle strobe qualifying rx_data; there is no
// back-pressure, every strobe is consumed in the cycle it arrives. wr_en is a
// one-cycle strobe; wr_addr/wr_data are valid with it and held until the next
// commit. frame_err is a one-cycle pulse and never coincides with wr_en.
module uart_frame_ctrl #(
  parameter logic [7:0]  HDR0         = 8'h55,
  parameter logic [7:0]  HDR1         = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 8680
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int unsigned   TW     = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    GOT_H0,
    GOT_H1,
    GOT_ADDR
`ifdef UART_FRAME_CHECKSUM_EN
    , GOT_DATA
`endif
  } state_t;

  // Current state is a plain named register so checkers can bind to it.
  state_t        state;
  state_t        state_next;
  logic [7:0]    addr_q;
  logic [TW-1:0] tcnt;
  logic          commit;
  logic          chk_err;
  logic          timeout_hit;
  logic [7:0]    commit_data;

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]    data_q;
  logic [7:0]    chk_sum;
  assign chk_sum = addr_q + data_q;
`endif

  // Next-state and commit/error decode; a byte always beats a timeout.
  always_comb begin
    state_next  = state;
    commit      = 1'b0;
    chk_err     = 1'b0;
    timeout_hit = 1'b0;
    commit_data = rx_data;
    if (rx_done) begin
      case (state)
        IDLE: begin
          if (rx_data == HDR0) state_next = GOT_H0;
        end
        GOT_H0: begin
          if (rx_data == HDR1)      state_next = GOT_H1;
          else if (rx_data == HDR0) state_next = GOT_H0;
          else                      state_next = IDLE;
        end
        GOT_H1: begin
          state_next = GOT_ADDR;
        end
        GOT_ADDR: begin
`ifdef UART_FRAME_CHECKSUM_EN
          state_next = GOT_DATA;
`else
          commit      = 1'b1;
          commit_data = rx_data;
          state_next  = IDLE;
`endif
        end
`ifdef UART_FRAME_CHECKSUM_EN
        GOT_DATA: begin
          commit_data = data_q;
          if (rx_data == chk_sum) commit  = 1'b1;
          else                    chk_err = 1'b1;
          state_next = IDLE;
        end
`endif
        default: state_next = IDLE;
      endcase
    end else if (state != IDLE && tcnt == T_LAST) begin
      timeout_hit = 1'b1;
      state_next  = IDLE;
    end
  end

  // State register, frame byte capture, output strobes and good-frame count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_cnt <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      data_q    <= '0;
`endif
    end else begin
      state     <= state_next;
      busy      <= (state_next != IDLE);
      wr_en     <= commit;
      frame_err <= chk_err | timeout_hit;
      if (commit) begin
        wr_addr   <= addr_q;
        wr_data   <= commit_data;
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (timeout_hit) begin
        addr_q <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
        data_q <= '0;
`endif
      end else if (rx_done) begin
        if (state == GOT_H1) addr_q <= rx_data;
`ifdef UART_FRAME_CHECKSUM_EN
        if (state == GOT_ADDR) data_q <= rx_data;
`endif
      end
    end
  end

  // Inter-byte timeout counter: runs only while a frame is pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
    end else if (rx_done || state == IDLE || timeout_hit) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed vector table, hand-written corner sequences
// (timeout, timeout boundary, mid-frame reset, frame counter wrap) and a
// randomized byte stream checked against a queue-based frame model.
module tb_uart_frame_ctrl;

  localparam int         T    = 24;
  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hA5;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CHK       = 1'b1;
  localparam int FRAME_LEN = 5;
`else
  localparam bit CHK       = 1'b0;
  localparam int FRAME_LEN = 4;
`endif
  localparam int W = 26;  // {kind[1:0], addr[7:0], data[7:0], cnt[7:0]}

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       busy;
  logic [7:0] frame_cnt;

  uart_frame_ctrl #(.HDR0(HDR0), .HDR1(HDR1), .TIMEOUT_CLKS(T)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .busy(busy), .frame_cnt(frame_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;
  int n_err    = 0;
  bit mon_on   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // gap idle negedges, then a one-cycle strobe; returns just after the
  // sampling edge so registered outputs for this byte can be checked.
  task automatic drive_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input int last_gap);
    drive_byte(HDR0, 1);
    drive_byte(HDR1, 1);
    drive_byte(a, 1);
    if (CHK) begin
      drive_byte(d, 1);
      drive_byte(8'(a + d), last_gap);
    end else begin
      drive_byte(d, last_gap);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   part_q[$];
  logic [7:0]   m_cnt;
  logic [W-1:0] sb_e;

  // Frame model: bytes of the pending frame are kept in a queue; spacing is
  // the number of clock edges since the previous strobe.
  function automatic void model_byte(input logic [7:0] b, input int spacing);
    bit ok;
    if (part_q.size() > 0 && spacing > T) begin
      exp_q.push_back({2'd2, 8'h00, 8'h00, m_cnt});
      part_q.delete();
    end
    if (part_q.size() == 0) begin
      if (b == HDR0) part_q.push_back(b);
    end else if (part_q.size() == 1) begin
      if (b == HDR1) part_q.push_back(b);
      else if (b != HDR0) part_q.delete();
    end else begin
      part_q.push_back(b);
      if (part_q.size() == FRAME_LEN) begin
        if (CHK) ok = (part_q[FRAME_LEN-1] == 8'(part_q[2] + part_q[3]));
        else     ok = 1'b1;
        if (ok) begin
          m_cnt = m_cnt + 8'd1;
          exp_q.push_back({2'd1, part_q[2], part_q[3], m_cnt});
        end else begin
          exp_q.push_back({2'd2, 8'h00, 8'h00, m_cnt});
        end
        part_q.delete();
      end
    end
  endfunction

  // Pulse counters and in-order event scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) n_wr++;
      if (frame_err) n_err++;
      if (wr_en || frame_err) begin
        check("wr_err_exclusive", {31'd0, wr_en & frame_err}, 32'd0);
        if (mon_on) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got wr_en=%0b frame_err=%0b, required no event", wr_en, frame_err);
          end else begin
            sb_e = exp_q.pop_front();
            check("sb_kind", {30'd0, frame_err, wr_en}, {30'd0, sb_e[25:24]});
            if (sb_e[25:24] == 2'd1) begin
              check("sb_addr", {24'd0, wr_addr}, {24'd0, sb_e[23:16]});
              check("sb_data", {24'd0, wr_data}, {24'd0, sb_e[15:8]});
            end
            check("sb_cnt", {24'd0, frame_cnt}, {24'd0, sb_e[7:0]});
          end
        end
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [7:0] b;
    logic       busy;
    logic       wr;
    logic       err;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [7:0] b, input logic bz, input logic wr,
                              input logic er, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] c);
    vec_t v;
    v.b = b; v.busy = bz; v.wr = wr; v.err = er; v.addr = a; v.data = d; v.cnt = c;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  int         base_wr, base_err, k, seen, sel, nb, idx, g, lg;
  logic [7:0] a, d;
  logic [7:0] fb[$];

  initial begin
    do_reset();
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);

    vt.push_back(mk(8'h55, 1, 0, 0, 8'h00, 8'h00, 8'd0));
    vt.push_back(mk(8'hA5, 1, 0, 0, 8'h00, 8'h00, 8'd0));
    vt.push_back(mk(8'h10, 1, 0, 0, 8'h00, 8'h00, 8'd0));
    if (CHK) begin
      vt.push_back(mk(8'h3C, 1, 0, 0, 8'h00, 8'h00, 8'd0));
      vt.push_back(mk(8'h4C, 0, 1, 0, 8'h10, 8'h3C, 8'd1));
      vt.push_back(mk(8'h55, 1, 0, 0, 8'h00, 8'h00, 8'd0));
      vt.push_back(mk(8'hA5, 1, 0, 0, 8'h00, 8'h00, 8'd0));
      vt.push_back(mk(8'h10, 1, 0, 0, 8'h00, 8'h00, 8'd0));
      vt.push_back(mk(8'h3C, 1, 0, 0, 8'h00, 8'h00, 8'd0));
      vt.push_back(mk(8'h4D, 0, 0, 1, 8'h00, 8'h00, 8'd1));
    end else begin
      vt.push_back(mk(8'h3C, 0, 1, 0, 8'h10, 8'h3C, 8'd1));
    end
    vt.push_back(mk(8'h12, 0, 0, 0, 8'h00, 8'h00, 8'd0));
    vt.push_back(mk(8'h55, 1, 0, 0, 8'h00, 8'h00, 8'd0));
    vt.push_back(mk(8'h55, 1, 0, 0, 8'h00, 8'h00, 8'd0));
    vt.push_back(mk(8'hA5, 1, 0, 0, 8'h00, 8'h00, 8'd0));
    vt.push_back(mk(8'hF0, 1, 0, 0, 8'h00, 8'h00, 8'd0));
    if (CHK) begin
      vt.push_back(mk(8'h0F, 1, 0, 0, 8'h00, 8'h00, 8'd0));
      vt.push_back(mk(8'hFF, 0, 1, 0, 8'hF0, 8'h0F, 8'd2));
    end else begin
      vt.push_back(mk(8'h0F, 0, 1, 0, 8'hF0, 8'h0F, 8'd2));
    end
    vt.push_back(mk(8'h55, 1, 0, 0, 8'h00, 8'h00, 8'd0));
    vt.push_back(mk(8'h33, 0, 0, 0, 8'h00, 8'h00, 8'd0));
    vt.push_back(mk(8'hA5, 0, 0, 0, 8'h00, 8'h00, 8'd0));
    vt.push_back(mk(8'h10, 0, 0, 0, 8'h00, 8'h00, 8'd0));
    vt.push_back(mk(8'h55, 1, 0, 0, 8'h00, 8'h00, 8'd0));
    vt.push_back(mk(8'hA5, 1, 0, 0, 8'h00, 8'h00, 8'd0));
    vt.push_back(mk(8'h55, 1, 0, 0, 8'h00, 8'h00, 8'd0));
    if (CHK) begin
      vt.push_back(mk(8'hA5, 1, 0, 0, 8'h00, 8'h00, 8'd0));
      vt.push_back(mk(8'hFA, 0, 1, 0, 8'h55, 8'hA5, 8'd3));
    end else begin
      vt.push_back(mk(8'hA5, 0, 1, 0, 8'h55, 8'hA5, 8'd3));
    end

    for (int i = 0; i < vt.size(); i++) begin
      drive_byte(vt[i].b, 1);
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].busy});
      check($sformatf("vec%0d_wr_en", i), {31'd0, wr_en}, {31'd0, vt[i].wr});
      check($sformatf("vec%0d_frame_err", i), {31'd0, frame_err}, {31'd0, vt[i].err});
      if (vt[i].wr) begin
        check($sformatf("vec%0d_wr_addr", i), {24'd0, wr_addr}, {24'd0, vt[i].addr});
        check($sformatf("vec%0d_wr_data", i), {24'd0, wr_data}, {24'd0, vt[i].data});
      end
      if (vt[i].wr || vt[i].err)
        check($sformatf("vec%0d_frame_cnt", i), {24'd0, frame_cnt}, {24'd0, vt[i].cnt});
    end

    // Timeout in GOT_ADDR: frame_err exactly T edges after the last strobe.
    settle();
    base_err = n_err;
    drive_byte(HDR0, 1);
    drive_byte(HDR1, 1);
    drive_byte(8'h20, 1);
    seen = 0;
    for (k = 1; k <= T + 4; k++) begin
      @(negedge clk);
      if (frame_err) begin
        seen = k;
        break;
      end
    end
    check("tmo_latency", seen, T);
    check("tmo_busy_low", {31'd0, busy}, 32'd0);
    settle();
    check("tmo_err_count", n_err - base_err, 1);
    send_frame(8'h01, 8'h02, 1);
    check("after_tmo_wr_en", {31'd0, wr_en}, 32'd1);
    check("after_tmo_addr", {24'd0, wr_addr}, 32'h01);
    check("after_tmo_data", {24'd0, wr_data}, 32'h02);
    check("after_tmo_cnt", {24'd0, frame_cnt}, 32'd4);

    // Timeout while only HDR0 has been seen.
    settle();
    base_err = n_err;
    drive_byte(HDR0, 1);
    repeat (T + 4) @(negedge clk);
    #1;
    check("tmo_h0_err_count", n_err - base_err, 1);

    // Boundary: last strobe exactly T edges after the previous one wins.
    settle();
    base_err = n_err;
    send_frame(8'h01, 8'h02, T - 1);
    check("bnd_in_wr_en", {31'd0, wr_en}, 32'd1);
    check("bnd_in_cnt", {24'd0, frame_cnt}, 32'd5);
    settle();
    check("bnd_in_no_err", n_err - base_err, 0);
    base_wr = n_wr;
    send_frame(8'h01, 8'h02, T);
    check("bnd_out_wr_en", {31'd0, wr_en}, 32'd0);
    settle();
    check("bnd_out_err", n_err - base_err, 1);
    check("bnd_out_no_wr", n_wr - base_wr, 0);
    check("bnd_out_cnt", {24'd0, frame_cnt}, 32'd5);

    // Reset between ADDR and DATA drops the frame silently.
    base_err = n_err;
    base_wr  = n_wr;
    drive_byte(HDR0, 1);
    drive_byte(HDR1, 1);
    drive_byte(8'h10, 1);
    do_reset();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("mid_rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("mid_rst_cnt", {24'd0, frame_cnt}, 32'd0);
    drive_byte(8'h3C, 1);
    drive_byte(8'h4C, 1);
    repeat (T + 4) @(negedge clk);
    #1;
    check("mid_rst_no_err", n_err - base_err, 0);
    check("mid_rst_no_wr", n_wr - base_wr, 0);
    check("mid_rst_busy_after", {31'd0, busy}, 32'd0);

    // Randomized stream against the frame model.
    do_reset();
    part_q.delete();
    exp_q.delete();
    m_cnt  = 8'd0;
    mon_on = 1'b1;
    for (int f = 0; f < 120; f++) begin
      sel = $urandom_range(0, 9);
      a   = 8'($urandom);
      d   = 8'($urandom);
      fb.delete();
      if (sel == 0) fb.push_back(8'($urandom));
      fb.push_back(HDR0);
      fb.push_back(HDR1);
      fb.push_back(a);
      fb.push_back(d);
      if (CHK) fb.push_back((sel == 1) ? 8'(a + d + 8'd1) : 8'(a + d));
      nb  = (sel == 2) ? $urandom_range(1, fb.size() - 1) : fb.size();
      idx = $urandom_range(1, fb.size() - 1);
      case ($urandom_range(0, 4))
        0: lg = T - 2;
        1: lg = T - 1;
        2: lg = T;
        3: lg = T + 1;
        default: lg = T + 6;
      endcase
      for (int i = 0; i < nb; i++) begin
        g = (sel == 3 && i == idx) ? lg : $urandom_range(1, 3);
        model_byte(fb[i], g + 1);
        drive_byte(fb[i], g);
      end
    end
    if (part_q.size() > 0) exp_q.push_back({2'd2, 8'h00, 8'h00, m_cnt});
    repeat (T + 6) @(negedge clk);
    #1;
    mon_on = 1'b0;
    check("sb_drained", exp_q.size(), 0);
    check("rand_frame_cnt", {24'd0, frame_cnt}, {24'd0, m_cnt});

    // 256 good frames: counter reaches 255, then wraps to 0.
    do_reset();
    base_wr = n_wr;
    for (int i = 0; i < 256; i++) begin
      send_frame(8'(i), 8'(~i), 1);
      if (i == 254) check("wrap_cnt_255", {24'd0, frame_cnt}, 32'd255);
    end
    check("wrap_cnt_0", {24'd0, frame_cnt}, 32'd0);
    settle();
    check("wrap_wr_count", n_wr - base_wr, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Frame-level controller behind the UART byte receiver. Consumes the `rx_data`/`rx_done` byte stream, hunts for a two-byte header, collects address and data bytes, checks an optional checksum, and issues one single-cycle register-write strobe per valid frame. It also detects inter-byte timeouts and reports malformed frames. It sits between the byte receiver and the board's register/LED control logic.

## Interface

Parameters:
- `HDR0`, default 8'h55: first header byte.
- `HDR1`, default 8'hA5: second header byte.
- `TIMEOUT_CLKS`, default 8680: idle clocks allowed between bytes inside a frame. This is 2 byte-times at 50 MHz / 115200. Must be ≥ 2.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `rx_data` in 8: byte from the byte receiver. Valid only in the cycle `rx_done`=1.
- `rx_done` in 1: single-cycle byte-valid strobe.
- `wr_en` out 1: single-cycle register-write strobe.
- `wr_addr` out 8: write address. Valid while `wr_en`=1 and held afterwards.
- `wr_data` out 8: write data. Valid while `wr_en`=1 and held afterwards.
- `frame_err` out 1: single-cycle pulse on a checksum failure or timeout.
- `busy` out 1: high whenever the state is not IDLE.
- `frame_cnt` out 8: count of good frames, wraps 255→0.

## Operation

States: IDLE, GOT_H0, GOT_H1, GOT_ADDR, GOT_DATA. GOT_DATA exists only with checksum enabled.

All transitions happen only on `rx_done`=1, except timeout and reset.

- IDLE: byte==HDR0 → GOT_H0. Any other byte is ignored.
- GOT_H0:
  - byte==HDR1 → GOT_H1.
  - byte==HDR0 → stay in GOT_H0 (resync).
  - any other byte → IDLE. No error is raised.
- GOT_H1: latch byte into internal `addr_q` → GOT_ADDR.
- GOT_ADDR:
  - Checksum on: latch byte into `data_q` → GOT_DATA.
  - Checksum off: commit the frame with addr=`addr_q`, data=byte → IDLE.
- GOT_DATA: if byte == (`addr_q` + `data_q`) mod 256, commit → IDLE. Otherwise pulse `frame_err` → IDLE.

Commit:
- Load `wr_addr` and `wr_data`.
- Assert `wr_en` for one cycle.
- Increment `frame_cnt` (8-bit wrap).

Header bytes are never checksummed. The sum is an 8-bit unsigned add; the carry is discarded.

Timeout:
- Counter width is $clog2(TIMEOUT_CLKS).
- It is cleared on every `rx_done` and whenever the state is IDLE.
- Otherwise it increments by 1 each clock.
- On reaching TIMEOUT_CLKS-1 with no `rx_done` in that cycle: pulse `frame_err`, go to IDLE, discard `addr_q`/`data_q`.
- If `rx_done` arrives in the same cycle the timeout would fire, the byte wins and the timeout does not fire.

Timeout in GOT_H0 is an error too, so any partial frame left pending is reported.

## Timing

Reset values: state=IDLE, `wr_en`=0, `frame_err`=0, `busy`=0, `wr_addr`=0, `wr_data`=0, `frame_cnt`=0, timeout counter=0.

Reset dominates all other inputs. A reset mid-frame drops the frame without raising `frame_err`.

Latency:
- `wr_en` is registered and high exactly 1 clock after the `rx_done` cycle of the final byte.
- `frame_err` follows the same 1-clock latency after the checksum byte's `rx_done`.
- On timeout, `frame_err` rises 1 clock after the counter reaches TIMEOUT_CLKS-1.

`busy` is registered from state. It rises 1 clock after the HDR0 byte and falls in the same cycle `wr_en`/`frame_err` rises.

`wr_en` and `frame_err` are mutually exclusive and never both high.

Back-to-back frames are supported: an HDR0 strobe arriving in the cycle right after a commit is accepted. `rx_done` strobes are at least 2 clocks apart, which the byte receiver guarantees.

## Configuration

`UART_FRAME_CHECKSUM_EN`:
- Defined: frame is 5 bytes (HDR0, HDR1, ADDR, DATA, CHK). GOT_DATA is present and the checksum is verified; a mismatch pulses `frame_err`.
- Undefined: frame is 4 bytes (HDR0, HDR1, ADDR, DATA). GOT_DATA, `data_q` and the adder are not compiled. `frame_err` comes only from timeouts.

## Test plan

- Checksum on, bytes 55 A5 10 3C 4C → `wr_en` one clock after the last `rx_done`, `wr_addr`=8'h10, `wr_data`=8'h3C, `frame_cnt`=1, `frame_err` stays 0.
- Checksum on, bytes 55 A5 10 3C 4D → `frame_err` pulses once, no `wr_en`, `frame_cnt` unchanged, `busy`=0 afterwards.
- Resync: bytes 12 55 55 A5 F0 0F FF → exactly one commit with addr=F0, data=0F. No error for the leading 12 or the duplicate 55.
- Timeout: 55 A5 20, then silence for TIMEOUT_CLKS clocks → one `frame_err`, return to IDLE. A following valid frame 55 A5 01 02 03 commits normally.
- Boundary: last byte's `rx_done` lands exactly on counter==TIMEOUT_CLKS-1 → byte accepted, no timeout. Also 256 good frames → `frame_cnt` wraps to 0.
- Reset asserted between ADDR and DATA bytes → all outputs return to reset values, no `frame_err`. The trailing stray bytes after reset produce no commit unless they start with HDR0.
